// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 registered demultiplexer with a one-entry holding register per channel
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   single producer handshake, word steered by in_sel (0..3)
//   out_valid/out_ready         per-channel handshake, bit k for channel k
//   out_data                    channel k at [k*WIDTH +: WIDTH]
//   DEMUX4_BUF_COUNT_EN         adds cnt_sel/cnt_val per-channel 8-bit delivered-word counters
module demux4_buf #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data
`ifdef DEMUX4_BUF_COUNT_EN
  ,
  input  logic [1:0]         cnt_sel,
  output logic [7:0]         cnt_val
`endif
);
  logic [3:0] acc, drn, nxt;
  // a channel can take a word when empty or emptying this cycle
  assign in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
  always_comb begin
    acc = '0;
    drn = '0;
    nxt = '0;
    for (int k = 0; k < 4; k++) begin
      acc[k] = in_valid & in_ready & (in_sel == 2'(k));
      drn[k] = out_valid[k] & out_ready[k];
      nxt[k] = acc[k] | (out_valid[k] & ~drn[k]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= nxt;
      for (int k = 0; k < 4; k++)
        if (acc[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
    end
  end
`ifdef DEMUX4_BUF_COUNT_EN
  logic [7:0] cnt [4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (drn[k]) cnt[k] <= cnt[k] + 8'd1;
    end
  end
  assign cnt_val = cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: randomized and directed self-checking bench for demux4_buf against a per-channel slot model
module tb_demux4_buf;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [W-1:0] in_data = 0;
  logic [1:0] in_sel = 0;
  logic [3:0] out_valid, out_ready = 0;
  logic [4*W-1:0] out_data;
`ifdef DEMUX4_BUF_COUNT_EN
  logic [1:0] cnt_sel = 0;
  logic [7:0] cnt_val;
`endif
  int tests = 0, errs = 0;
  bit mfull [4];
  logic [W-1:0] mdat [4];
  int dcnt [4];
  logic [W-1:0] got_q [$];

  demux4_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef DEMUX4_BUF_COUNT_EN
    , .cnt_sel(cnt_sel), .cnt_val(cnt_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mfull[k] = 0;
      mdat[k] = '0;
      dcnt[k] = 0;
    end
    got_q.delete();
  endtask

  task automatic chk_out();
    logic [3:0] ev;
    logic [4*W-1:0] ed;
    for (int k = 0; k < 4; k++) begin
      ev[k] = mfull[k];
      ed[k*W +: W] = mdat[k];
    end
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
`ifdef DEMUX4_BUF_COUNT_EN
    chk("cnt_val", cnt_val, dcnt[cnt_sel]);
`endif
  endtask

  task automatic cyc();
    bit r;
    @(negedge clk);
    r = !mfull[in_sel] || out_ready[in_sel];
    chk("in_ready", in_ready, r);
    for (int k = 0; k < 4; k++)
      if (mfull[k] && out_ready[k]) begin
        mfull[k] = 0;
        dcnt[k] = (dcnt[k] + 1) % 256;
        if (k == 2) got_q.push_back(mdat[k]);
      end
    if (in_valid && r) begin
      mfull[in_sel] = 1;
      mdat[in_sel] = in_data;
    end
    @(posedge clk);
    #1;
    chk_out();
  endtask

  task automatic drv(bit v, logic [1:0] s, logic [W-1:0] d, logic [3:0] r);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
    cyc();
  endtask

  task automatic do_reset();
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_data", out_data, '0);
    chk("rst_ready", in_ready, 1'b0);
    model_clear();
    #3 rst = 0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    #2;
    chk("init_valid", out_valid, 4'b0000);
    chk("init_data", out_data, '0);
    chk("init_ready", in_ready, 1'b0);
    #5 rst = 0;
    @(posedge clk);
    #1;
    drv(1, 0, 8'hA5, 4'b0000);
    drv(1, 2, 8'h3C, 4'b0000);
    chk("full_valid", out_valid, 4'b0101);
    do_reset();
    drv(1, 1, 8'h5A, 4'b0000);
    chk("steer_valid", out_valid, 4'b0010);
    chk("steer_data", out_data[15:8], 8'h5A);
    drv(1, 3, 8'hC3, 4'b0000);
    in_sel = 3;
    in_data = 8'h11;
    #1;
    chk("bp_ready3", in_ready, 1'b0);
    cyc();
    drv(1, 0, 8'h22, 4'b0000);
    chk("bp_data0", out_data[7:0], 8'h22);
    chk("bp_data3", out_data[31:24], 8'hC3);
    for (int i = 1; i <= 16; i++) begin
      drv(1, 2, W'(i), 4'b0100);
      chk("stream_valid", out_valid[2], 1'b1);
    end
    drv(0, 0, 0, 4'b0100);
    chk("stream_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("stream_word", got_q[i], W'(i + 1));
    do_reset();
    drv(1, 0, 8'h10, 4'b0000);
    drv(1, 1, 8'h20, 4'b0000);
    drv(1, 2, 8'h30, 4'b0000);
    drv(1, 0, 8'h77, 4'b0111);
    chk("sim_valid", out_valid, 4'b0001);
    chk("sim_data", out_data[7:0], 8'h77);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
`ifdef DEMUX4_BUF_COUNT_EN
      cnt_sel = 2'($urandom_range(0, 3));
`endif
      drv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), 4'($urandom));
    end
`ifdef DEMUX4_BUF_COUNT_EN
    do_reset();
    cnt_sel = 1;
    repeat (258) drv(1, 1, W'($urandom), 4'b0010);
    drv(0, 0, 0, 4'b0010);
    chk("cnt_wrap", cnt_val, 8'd2);
    cnt_sel = 0;
    #1;
    chk("cnt_ch0", cnt_val, 8'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 1-to-4 registered demultiplexer; the inverse of the team's 2:1/N:1 select mux path.
- Accepts one word per cycle on a single valid/ready input and steers it to the output channel chosen by in_sel.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between the CPU write-back/data bus and up to four destinations (register bank, I/O latch, memory write port, debug tap).

Parameters:
- WIDTH, 8, data word width in bits (legal 1..32).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel index 0..3.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Reset: clock is one clock; reset is asynchronous and active-high.
  - While rst=1: all out_valid=0, all out_data=0.
  - in_ready=0 while rst=1 and follows the rule below once rst=0.
  - Reset asserted mid-transfer discards held words; there is no partial output.
- Per-channel state machine (k=0..3): EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
  - acc = in_valid & in_ready & (in_sel==k).
  - drn = out_valid[k] & out_ready[k].
  - EMPTY, acc -> FULL; data register loads in_data.
  - FULL, drn & ~acc -> EMPTY; data register holds its value (not cleared).
  - FULL, drn & acc -> FULL; data register loads the new word (back-to-back, no bubble).
  - FULL, ~drn -> FULL; data register holds.
  - acc is impossible unless the channel is EMPTY or draining (see in_ready).
- in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - Combinational from in_sel and out_ready; no dependence on in_valid.
  - in_sel changes only affect which channel is checked.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N, visible in cycle N+1.
- Throughput: 1 word/cycle sustained to a single channel whose consumer holds out_ready=1.
- Only one channel can load per cycle. Any number of channels can drain in the same cycle.
- Ordering is preserved per channel. No ordering is guaranteed across channels.
- out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- in_sel and in_data are don't-care when in_valid=0 and do not change any state.
- No word is ever dropped or duplicated.

Optional Feature:
- Macro: DEMUX4_BUF_COUNT_EN.
- Defined:
  - Adds input cnt_sel (2 bits) and output cnt_val (8 bits).
  - Each channel keeps an 8-bit delivered-word counter; it increments on drn for that channel.
  - Counters wrap from 255 to 0 and reset to 0 on rst.
  - cnt_val = counter[cnt_sel], combinational.
- Undefined:
  - The ports and counters are absent.
  - Core datapath behaviour is identical in both builds.

Test Plan:
- Reset with channels full:
  - Stimulus: load channels 0 and 2 (0xA5, 0x3C), hold out_ready=0, pulse rst asynchronously mid-cycle.
  - Required: out_valid=4'b0000 and out_data=0 immediately; in_ready=1 after rst falls.
- Latency and steering:
  - Stimulus: in_valid=1, in_sel=1, in_data=0x5A for one cycle, out_ready=4'b0000.
  - Required: next cycle out_valid=4'b0010, channel-1 data=0x5A, other channels unchanged.
- Per-channel backpressure:
  - Stimulus: channel 3 full with out_ready[3]=0; offer 0x11 to channel 3, then 0x22 to channel 0.
  - Required: in_ready=0 for channel 3 and 0x11 is held at the producer; in_ready=1 for channel 0 and 0x22 lands there; channel-3 data remains stable.
- Back-to-back streaming:
  - Stimulus: stream 0x01..0x10 to channel 2 with out_ready[2]=1 continuously.
  - Required: in_ready stays 1; out_valid[2] stays 1 from cycle 2; consumer receives 16 words in order, no bubbles.
- Simultaneous events:
  - Stimulus: channel 0 full and draining while a new word 0x77 is accepted to channel 0; channels 1 and 2 drain in the same cycle.
  - Required: channel 0 stays FULL with 0x77; channels 1 and 2 go EMPTY.
- Counter build (DEMUX4_BUF_COUNT_EN defined):
  - Stimulus: drain 258 words through channel 1.
  - Required: cnt_sel=1 gives cnt_val=2 (wrapped); cnt_sel=0 gives cnt_val=0.
